// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter and busy scoreboard for the 32x32 register file.
// Three writeback sources (ALU, load, mul/div) share the single write port
// through round-robin valid/ready handshakes. The write beat is registered
// toward the file, and a per-register busy scoreboard lets decode stall on
// outstanding writes.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [ADDR_W-1:0]     req_addr0,
  input  logic [ADDR_W-1:0]     req_addr1,
  input  logic [ADDR_W-1:0]     req_addr2,
  input  logic [DATA_W-1:0]     req_data0,
  input  logic [DATA_W-1:0]     req_data1,
  input  logic [DATA_W-1:0]     req_data2,
  input  logic                  hold,
  output logic                  RegWr,
  output logic [ADDR_W-1:0]     RW,
  output logic [DATA_W-1:0]     BusW,
  output logic [1:0]            grant_id,
  input  logic                  claim_valid,
  input  logic [ADDR_W-1:0]     claim_addr,
  output logic [(1<<ADDR_W)-1:0] busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        ptr_q, ptr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rw_q;
  logic [DATA_W-1:0] busw_q;
  logic [1:0]        gid_q;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              xfer;
  logic [1:0]        win;
  logic [1:0]        cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Successor of a source index in the ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Round-robin scan starting at ptr; depends only on valid, ptr, hold, Rst.
  always_comb begin
    xfer = 1'b0;
    win  = 2'd0;
    cand = ptr_q;
    if (Rst && !hold) begin
      for (int k = 0; k < 3; k++) begin
        if (!xfer && req_valid[cand]) begin
          xfer = 1'b1;
          win  = cand;
        end
        cand = next_src(cand);
      end
    end
    req_ready = xfer ? (3'b001 << win) : 3'b000;
  end

  // Winning source's address/data and the next-state of pointer and write beat.
  always_comb begin
    case (win)
      2'd1:    begin sel_addr = req_addr1; sel_data = req_data1; end
      2'd2:    begin sel_addr = req_addr2; sel_data = req_data2; end
      default: begin sel_addr = req_addr0; sel_data = req_data0; end
    endcase
    ptr_d = xfer ? next_src(win) : ptr_q;
    // Register 0 is hardwired: the beat is drained but never written.
    wr_d  = xfer && (sel_addr != '0);
  end

  // Scoreboard next-state: transfer clears, claim sets, a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer)        busy_d[sel_addr]   = 1'b0;
    if (claim_valid) busy_d[claim_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Pointer and registered write beat; address/data hold when nothing is written.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr_q  <= 2'd0;
      wr_q   <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
      gid_q  <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      if (wr_d) begin
        rw_q   <= sel_addr;
        busw_q <= sel_data;
        gid_q  <= win;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign RegWr    = wr_q;
  assign RW       = rw_q;
  assign BusW     = busw_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

endmodule
